ifetch_queue: RTL

//   Instruction fetch front end sitting between instruction memory and the pipeline's ID stage.

---
 rtl/ifetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - in-order instruction fetch front end with a small {pc,ir} FIFO
// Issues pipelined memory reads against reserved FIFO credit and flushes on redirect.
module ifetch_queue #(
    parameter int            DEPTH    = 4,
    parameter int            MAX_OUT  = 2,
    parameter int            AW       = 11,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          deq,
    output logic          ir_valid,
    output logic [DW-1:0] ir_out,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] im_addr,
    output logic          im_oen,
    input  logic [DW-1:0] im_data,
    input  logic          im_ack
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [AW-1:0] pc_mem [DEPTH];
    logic [DW-1:0] ir_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outst;
    logic [OW-1:0] drop_cnt;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] resp_pc;

    logic issue;
    logic ack_v;
    logic push;
    logic pop;

    always_comb begin
        ack_v = im_ack && (outst != '0);
        // Each request holds a FIFO slot until its word is consumed, so a push can never overflow.
        issue = !rst && !redirect
                && (int'(outst) < MAX_OUT)
                && (int'(count) + int'(outst) < DEPTH);
        push  = ack_v && !redirect && (drop_cnt == '0);
        pop   = deq && (count != '0) && !redirect;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outst    <= '0;
            drop_cnt <= '0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else begin
            outst <= outst + OW'(issue) - OW'(ack_v);
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // Every request still in flight belongs to the abandoned stream.
                drop_cnt <= outst - OW'(ack_v);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + AW'(1);
                end
                if (ack_v && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr] <= resp_pc;
            ir_mem[wr_ptr] <= im_data;
        end
    end

    assign ir_valid = (count != '0);
    assign ir_out   = ir_valid ? ir_mem[rd_ptr] : '0;
    assign pc_out   = ir_valid ? pc_mem[rd_ptr] : '0;
    assign im_addr  = fetch_pc;
    assign im_oen   = !issue;

endmodule
